// File: rtl/enemy_sprite_pkg.sv
// Shared constants and FSM state type for the enemy sprite scheduler.
package enemy_sprite_pkg;
    localparam int SPRITE_W  = 32;
    localparam int SPRITE_H  = 32;
    localparam int SPRITE_AW = 5;

    localparam logic [23:0] DEF_TRANSPARENT = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row: 32 colour registers, synchronous write, asynchronous read.
module sprite_line_buf
    import enemy_sprite_pkg::*;
#(
    parameter int COLOR_BITS = 24
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [SPRITE_AW-1:0]  waddr,
    input  logic [COLOR_BITS-1:0] wdata,
    input  logic [SPRITE_AW-1:0]  raddr,
    output logic [COLOR_BITS-1:0] rdata
);
    logic [COLOR_BITS-1:0] mem [SPRITE_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/enemy_sprite_scheduler.sv
// Prefetches next-line sprite rows for N enemies from one shared ROM into
// double-buffered line buffers and composites the front bank per pixel.
module enemy_sprite_scheduler
    import enemy_sprite_pkg::*;
#(
    parameter int N_ENEMY    = 4,
    parameter int ADDRESS    = 10,
    parameter int COLOR_BITS = 24,
    parameter int COORD_BITS = 10,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT = COLOR_BITS'(DEF_TRANSPARENT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          line_start,
    input  logic [COORD_BITS-1:0]         line_y,
    input  logic [N_ENEMY*COORD_BITS-1:0] enemy_x,
    input  logic [N_ENEMY*COORD_BITS-1:0] enemy_y,
    input  logic [N_ENEMY-1:0]            enemy_en,
    output logic [ADDRESS-1:0]            rom_addr,
    input  logic [COLOR_BITS-1:0]         rom_data,
    input  logic                          pix_valid,
    input  logic [COORD_BITS-1:0]         pix_x,
    output logic [COLOR_BITS-1:0]         pix_color,
    output logic                          pix_hit,
    output logic                          fetch_busy,
    output logic                          fetch_overrun
);
    localparam int IW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

    fetch_state_e                        state;
    logic [IW-1:0]                       idx;
    logic [SPRITE_AW-1:0]                col;
    logic [COORD_BITS-1:0]               ly;
    logic                                sel;    // index of the back bank
    logic [1:0][N_ENEMY-1:0]             valid;
    logic [1:0][N_ENEMY-1:0][COORD_BITS-1:0] xs;

    logic [COORD_BITS:0] dy;
    logic                row_hit, last, wr_ok;

    assign dy         = {1'b0, ly} - {1'b0, enemy_y[idx*COORD_BITS +: COORD_BITS]};
    assign row_hit    = enemy_en[idx] && !dy[COORD_BITS] && (dy[COORD_BITS-1:SPRITE_AW] == '0);
    assign last       = (idx == IW'(N_ENEMY - 1));
    assign fetch_busy = (state != IDLE);
    // A fetch write landing on the swap cycle belongs to an abandoned row.
    assign wr_ok      = (state == FETCH) && !line_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            col           <= '0;
            ly            <= '0;
            sel           <= 1'b0;
            valid         <= '0;
            xs            <= '0;
            rom_addr      <= '0;
            fetch_overrun <= 1'b0;
        end else begin
            fetch_overrun <= line_start && (state != IDLE);
            if (line_start) begin
                sel         <= ~sel;
                valid[~sel] <= '0;
                ly          <= line_y;
                idx         <= '0;
                state       <= SCAN;
            end else begin
                case (state)
                    SCAN: begin
                        if (row_hit) begin
                            xs[sel][idx] <= enemy_x[idx*COORD_BITS +: COORD_BITS];
                            col          <= '0;
                            rom_addr     <= ADDRESS'({dy[SPRITE_AW-1:0], {SPRITE_AW{1'b0}}});
                            state        <= FETCH;
                        end else if (last) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    FETCH: begin
                        rom_addr <= {rom_addr[ADDRESS-1:SPRITE_AW], col + 1'b1};
                        col      <= col + 1'b1;
                        if (col == SPRITE_AW'(SPRITE_W - 1)) begin
                            valid[sel][idx] <= 1'b1;
                            if (last) begin
                                state <= IDLE;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= SCAN;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [COLOR_BITS-1:0] rd   [2][N_ENEMY];
    logic [COLOR_BITS-1:0] fcol [N_ENEMY];
    logic [N_ENEMY-1:0]    cand;

    for (genvar e = 0; e < N_ENEMY; e++) begin : g_enemy
        logic [COORD_BITS:0] dx;
        assign dx = {1'b0, pix_x} - {1'b0, xs[~sel][e]};

        for (genvar b = 0; b < 2; b++) begin : g_bank
            sprite_line_buf #(.COLOR_BITS(COLOR_BITS)) u_buf (
                .clk   (clk),
                .we    (wr_ok && (sel == 1'(b)) && (idx == IW'(e))),
                .waddr (col),
                .wdata (rom_data),
                .raddr (dx[SPRITE_AW-1:0]),
                .rdata (rd[b][e])
            );
        end

        assign fcol[e] = sel ? rd[0][e] : rd[1][e];
        assign cand[e] = valid[~sel][e] && !dx[COORD_BITS] &&
                         (dx[COORD_BITS-1:SPRITE_AW] == '0) && (fcol[e] != TRANSPARENT);
    end

    logic [COLOR_BITS-1:0] win;
    logic                  any;

    // Walk from the highest index down so the lowest-index candidate wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int e = N_ENEMY - 1; e >= 0; e--) begin
            if (cand[e]) begin
                win = fcol[e];
                any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_hit   <= 1'b0;
            pix_color <= '0;
        end else begin
            pix_hit   <= pix_valid && any;
            pix_color <= (pix_valid && any) ? win : '0;
        end
    end
endmodule

// File: tb/tb_enemy_sprite_scheduler.sv
// Directed + randomized bench for enemy_sprite_scheduler with a line-level reference model.
module tb_enemy_sprite_scheduler;
    localparam int N  = 4;
    localparam int CB = 10;
    localparam logic [23:0] TR = 24'hFF00FF;
    localparam int BIG = 100000;

    logic          clk = 1'b0, rst_n = 1'b1, line_start = 1'b0;
    logic [CB-1:0] line_y = '0;
    logic [N*CB-1:0] enemy_x = '0, enemy_y = '0;
    logic [N-1:0]  enemy_en = '0;
    logic [9:0]    rom_addr;
    logic [23:0]   rom_data;
    logic          pix_valid = 1'b0;
    logic [CB-1:0] pix_x = '0;
    logic [23:0]   pix_color;
    logic          pix_hit, fetch_busy, fetch_overrun;

    enemy_sprite_scheduler dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_en(enemy_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_color(pix_color), .pix_hit(pix_hit),
        .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [1024];
    assign rom_data = rom[rom_addr];

    int ov_cnt = 0;
    always @(negedge clk) if (fetch_overrun === 1'b1) ov_cnt <= ov_cnt + 1;

    // Reference model: enemy setup plus front/back row images.
    int          ex[N], ey[N];
    bit          een[N];
    logic [23:0] fr_row[N][32], bk_row[N][32];
    bit          fr_v[N], bk_v[N];
    int          fr_x[N], bk_x[N];

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_enemy(input int k, input int x, input int y, input bit en);
        ex[k] = x; ey[k] = y; een[k] = en;
        enemy_x[k*CB +: CB] = x[CB-1:0];
        enemy_y[k*CB +: CB] = y[CB-1:0];
        enemy_en[k] = en;
    endtask

    // Swap, then rebuild the back bank; an enemy counts only if its last
    // column lands strictly before the next line_start (gap edges later).
    task automatic model_line(input int ly, input int gap);
        int t, dy;
        for (int k = 0; k < N; k++) begin
            fr_v[k] = bk_v[k]; fr_x[k] = bk_x[k];
            for (int c = 0; c < 32; c++) fr_row[k][c] = bk_row[k][c];
        end
        t = 1;
        for (int k = 0; k < N; k++) begin
            dy = ly - ey[k];
            if (een[k] && dy >= 0 && dy < 32) begin
                if (t + 32 < gap) begin
                    bk_v[k] = 1; bk_x[k] = ex[k];
                    for (int c = 0; c < 32; c++) bk_row[k][c] = rom[dy*32 + c];
                end else bk_v[k] = 0;
                t += 33;
            end else begin
                bk_v[k] = 0;
                t += 1;
            end
        end
    endtask

    task automatic exp_pix(input int px, input bit pv, output bit h, output logic [23:0] c);
        h = 0; c = '0;
        for (int k = 0; k < N; k++) begin
            if (!h && pv && fr_v[k] && px >= fr_x[k] && px - fr_x[k] < 32 &&
                fr_row[k][px - fr_x[k]] != TR) begin
                h = 1; c = fr_row[k][px - fr_x[k]];
            end
        end
    endtask

    task automatic pulse(input int ly, input int gap);
        model_line(ly, gap);
        @(negedge clk); line_y = ly[CB-1:0]; line_start = 1'b1;
        @(negedge clk); line_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int c = 0;
        while (fetch_busy && c < 300) begin @(negedge clk); c++; end
        chk(tag, 32'(c <= maxc), 32'd1);
    endtask

    task automatic line2(input int ly);
        pulse(ly, BIG); wait_idle("busy_a", 132);
        pulse(ly, BIG); wait_idle("busy_b", 132);
    endtask

    task automatic pix(input string tag, input int px, input bit pv);
        bit h; logic [23:0] c;
        @(negedge clk); pix_x = px[CB-1:0]; pix_valid = pv;
        exp_pix(px, pv, h, c);
        @(negedge clk);
        chk({tag, "_hit"}, 32'(pix_hit), 32'(h));
        chk({tag, "_col"}, 32'(pix_color), 32'(c));
    endtask

    initial begin
        logic [23:0] v;
        logic [9:0]  a0;
        int ly, y, k, px, ov0;
        for (int i = 0; i < 1024; i++) begin
            v = 24'($urandom);
            if (v == TR) v = v ^ 24'h1;
            rom[i] = v;
        end
        for (int i = 0; i < N; i++) begin
            set_enemy(i, 0, 900, 0);
            bk_v[i] = 0; fr_v[i] = 0; bk_x[i] = 0; fr_x[i] = 0;
        end

        #1 rst_n = 1'b0;
        #12;
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_hit", 32'(pix_hit), 0);
        chk("rst_col", 32'(pix_color), 0);
        chk("rst_busy", 32'(fetch_busy), 0);
        chk("rst_ovr", 32'(fetch_overrun), 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: single enemy, address sequence and first hit
        set_enemy(0, 100, 50, 1);
        pulse(60, BIG);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("t1_addr", 32'(rom_addr), 32'(320 + c));
        end
        wait_idle("t1_busy", 100);
        pulse(60, BIG);
        wait_idle("t1_busy2", 132);
        pix("t1_px105", 105, 1);
        chk("t1_rom325", 32'(pix_color), 32'(rom[325]));
        pix("t1_novalid", 105, 0);

        // 2: transparency key, enemy behind shows through
        rom[325] = TR;
        line2(60);
        pix("t2_transp", 105, 1);
        set_enemy(1, 103, 55, 1);
        line2(60);
        pix("t2_behind", 105, 1);
        chk("t2_e1col", 32'(pix_color), 32'(rom[162]));
        pix("t2_front", 106, 1);

        // 3: priority
        set_enemy(0, 190, 50, 1); set_enemy(1, 0, 900, 0); set_enemy(2, 180, 40, 1);
        line2(60);
        pix("t3_prio", 200, 1);
        set_enemy(0, 190, 50, 0);
        line2(60);
        pix("t3_e2", 200, 1);
        set_enemy(2, 0, 900, 0);

        // 4: vertical / horizontal bounds, no wrap
        set_enemy(0, 100, 50, 1);
        line2(81);
        pix("t4_x99", 99, 1);
        pix("t4_x100", 100, 1);
        pix("t4_x131", 131, 1);
        pix("t4_x132", 132, 1);
        a0 = rom_addr;
        pulse(82, BIG); wait_idle("t4_idle82", 4);
        chk("t4_noaddr82", 32'(rom_addr), 32'(a0));
        pulse(49, BIG); wait_idle("t4_idle49", 4);
        chk("t4_noaddr49", 32'(rom_addr), 32'(a0));
        pix("t4_y82", 100, 1);
        pulse(49, BIG); wait_idle("t4_idle49b", 4);
        pix("t4_y49", 100, 1);
        set_enemy(0, 1000, 50, 1);
        line2(60);
        pix("t4_x999", 999, 1);
        pix("t4_x1023", 1023, 1);
        pix("t4_x0", 0, 1);
        pix("t4_x5", 5, 1);

        // 5: overrun 40 cycles into a 4-enemy prefetch
        for (int i = 0; i < N; i++) set_enemy(i, 300 + 40*i, 100, 1);
        pulse(110, BIG); wait_idle("t5_full", 132);
        ov0 = ov_cnt;
        pulse(115, 40);
        repeat (38) @(negedge clk);
        pulse(115, BIG);
        wait_idle("t5_busy", 132);
        chk("t5_ovr_once", 32'(ov_cnt - ov0), 32'd1);
        pix("t5_e0", 305, 1);
        pix("t5_e1gone", 345, 1);
        pix("t5_e2gone", 385, 1);

        // 6: async reset mid-fetch
        pulse(110, BIG);
        repeat (10) @(negedge clk);
        pix("t6_pre", 305, 1);
        chk("t6_busy", 32'(fetch_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_addr", 32'(rom_addr), 0);
        chk("t6_hit", 32'(pix_hit), 0);
        chk("t6_col", 32'(pix_color), 0);
        chk("t6_busy0", 32'(fetch_busy), 0);
        for (int i = 0; i < N; i++) begin
            bk_v[i] = 0; fr_v[i] = 0; bk_x[i] = 0; fr_x[i] = 0;
        end
        @(negedge clk) rst_n = 1'b1;
        pix("t6_none0", 305, 1);
        pulse(110, BIG); wait_idle("t6_w1", 132);
        pix("t6_none1", 305, 1);
        pulse(110, BIG); wait_idle("t6_w2", 132);
        pix("t6_back", 305, 1);

        // Randomized lines with sprinkled transparent pixels
        for (int i = 0; i < 1024; i++) if ($urandom_range(0, 7) == 0) rom[i] = TR;
        for (int r = 0; r < 6; r++) begin
            ly = $urandom_range(0, 1023);
            for (int i = 0; i < N; i++) begin
                y = ly - int'($urandom_range(0, 40));
                if (y < 0) y = 0;
                set_enemy(i, $urandom_range(0, 1023), y, $urandom_range(0, 3) != 0);
            end
            line2(ly);
            for (int p = 0; p < 24; p++) begin
                k  = $urandom_range(0, N-1);
                px = ex[k] + int'($urandom_range(0, 35)) - 2;
                if (px < 0) px = 0;
                if (px > 1023) px = 1023;
                pix("rnd", px, $urandom_range(0, 7) != 0);
            end
        end

        chk("ovr_total", 32'(ov_cnt), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enemy_sprite_scheduler.md
Name: enemy_sprite_scheduler

Overview:
Shares one asynchronous-read enemy sprite ROM (32x32 pixels, 24-bit RGB, 10-bit address) between N on-screen enemies. It sits between the VGA timing/game-state logic and the pixel mux.
- During each scanline it prefetches the sprite row that the next line needs for every enemy into per-enemy line buffers (back bank).
- At the next line start the back bank is swapped to the front bank.
- During the active scan it composites the front bank, applying priority and a transparency key.

Parameters:
N_ENEMY, 4, number of enemies sharing the ROM
ADDRESS, 10, ROM address width; must equal log2(SPRITE_W*SPRITE_H)
COLOR_BITS, 24, pixel colour width
COORD_BITS, 10, screen coordinate width
TRANSPARENT, 24'hFF00FF, colour key treated as "no pixel"

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
line_start  in  1  one-cycle pulse; starts prefetch for line_y and swaps banks
line_y  in  COORD_BITS  screen row to prefetch (sampled on line_start)
enemy_x  in  N_ENEMY*COORD_BITS  left edge per enemy, flattened; enemy i at [i*COORD_BITS +: COORD_BITS]
enemy_y  in  N_ENEMY*COORD_BITS  top edge per enemy, flattened
enemy_en  in  N_ENEMY  enemy alive/visible
rom_addr  out  ADDRESS  sprite ROM address (registered)
rom_data  in  COLOR_BITS  sprite ROM data, combinational from rom_addr
pix_valid  in  1  active-video qualifier
pix_x  in  COORD_BITS  current pixel column
pix_color  out  COLOR_BITS  composited enemy colour (0 when no hit)
pix_hit  out  1  an opaque enemy pixel covers pix_x
fetch_busy  out  1  prefetch FSM not idle
fetch_overrun  out  1  one-cycle pulse: line_start arrived while busy

Behaviour:
- Reset:
  - All outputs 0; FSM IDLE; both banks' valid bits 0; stored x positions 0.
  - Buffer contents are don't-care.
- Bank swap on a line_start cycle:
  - front <= back (colours, valid bits, snapshotted x).
  - Back valid bits are cleared, line_y is latched, enemy index i = 0, and the FSM enters SCAN next cycle.
- SCAN (1 cycle per enemy):
  - dy = line_y - enemy_y[i], computed at COORD_BITS+1 bits.
  - Row match when enemy_en[i] is set, there is no borrow, and dy < 32.
  - Match: snapshot enemy_x[i] into back_x[i], col = 0, rom_addr = {dy[4:0], 5'd0}, go to FETCH.
  - No match: i++, or go to IDLE after i = N_ENEMY-1.
- FETCH:
  - Each cycle writes back[i][col] <= rom_data; the ROM is async, so data is valid during the same cycle rom_addr is held.
  - rom_addr is advanced to the next column; col++.
  - At col = 31: set back_valid[i], i++, then return to SCAN, or go to IDLE if i was the last enemy.
- Worst-case prefetch: N_ENEMY*33 cycles after line_start (132 for the default).
- fetch_busy = 1 in SCAN/FETCH.
- line_start while busy:
  - fetch_overrun pulses and the swap still occurs.
  - Partially fetched enemies have back_valid 0, so they do not appear in front.
  - Prefetch restarts for the new line_y.
- Compositing (registered, 1-cycle latency from pix_x/pix_valid to pix_color/pix_hit):
  - Per enemy: dx = pix_x - front_x[i], computed at COORD_BITS+1 bits.
  - Candidate when front_valid[i] is set, there is no borrow, dx < 32, and front[i][dx[4:0]] != TRANSPARENT.
  - The lowest-index candidate wins.
  - pix_hit = pix_valid && any candidate; pix_color = winner colour, else 0.
- No screen wrap: an enemy at x = 1000 is only visible for pix_x in 1000..1023.
- enemy_x/enemy_y changes mid-line do not affect the front bank. They affect a fetch only if the change lands before that enemy's SCAN cycle.

Decomposition:
- Package enemy_sprite_pkg holds:
  - SPRITE_W = 32, SPRITE_H = 32, SPRITE_AW = 5;
  - default TRANSPARENT;
  - typedef enum of FSM states {IDLE, SCAN, FETCH}.
- Sub-module sprite_line_buf: 32 x COLOR_BITS register array with a synchronous write port (we, waddr, wdata) and an async read port.
  - Instantiated 2*N_ENEMY times (front/back per enemy).
  - The swap is implemented as a bank-select toggle rather than a copy.

Test Plan:
1. Enemy 0 at (100,50), enabled, line_y = 60 pulse → rom_addr steps 320..351 on cycles 2..33 after the pulse; fetch_busy falls by cycle N*33. After the next line_start, pix_x = 105 yields the ROM word at 325 one cycle later with pix_hit = 1.
2. ROM word = TRANSPARENT at that pixel → pix_hit = 0, pix_color = 0. Enemy 1 behind it and opaque → enemy 1's colour shown.
3. Enemies 0 and 2 both cover pix_x = 200, both opaque → enemy 0's colour wins; disabling enemy 0 shows enemy 2.
4. Vertical bounds: enemy_y = 50 with line_y = 81 → fetched. line_y = 82 or 49 → no ROM fetch, no hit. Horizontal: pix_x = 99 and 132 → no hit.
5. line_start again 40 cycles after a line_start with all 4 enemies matching → fetch_overrun pulses once. Only enemy 0 is valid in the front bank; enemy 1 (partial) is absent.
6. rst_n low mid-FETCH → outputs 0 asynchronously; after release there are no hits until two line_start pulses have completed prefetch.
